// File: rtl/maze_pkg.sv
// Shared definitions for the maze loader: job modes, FSM states, cell codes,
// default geometry and the LFSR reload value and step function.
package maze_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_CLEAR  = 2'd2,
    MODE_RANDOM = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam logic [1:0] CELL_PATH  = 2'd0;
  localparam logic [1:0] CELL_WALL  = 2'd1;
  localparam logic [1:0] CELL_START = 2'd2;
  localparam logic [1:0] CELL_EXIT  = 2'd3;

  localparam int DEFAULT_MAZE_W = 16;
  localparam int DEFAULT_MAZE_H = 16;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // 16-bit Fibonacci step, taps 16,14,13,11, shifting towards the MSB
  function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

endpackage

// File: rtl/maze_level_rom.sv
// Level bitmap ROM: returns one maze row, MSB is column 0.
// Bitmaps are generated from simple geometric rules so they scale with the
// maze size; level 0 is solid wall, the others are bordered patterns.
module maze_level_rom
  import maze_pkg::*;
#(
  parameter int MAZE_W = DEFAULT_MAZE_W,
  parameter int MAZE_H = DEFAULT_MAZE_H,
  localparam int ROW_W = $clog2(MAZE_H)
) (
  input  logic [2:0]        level_i,
  input  logic [ROW_W-1:0]  row_i,
  output logic [MAZE_W-1:0] row_bits_o
);

  function automatic logic levelWall(input logic [2:0] lvl, input int x, input int y);
    logic border;
    logic wall;
    border = (x == 0) || (x == MAZE_W - 1) || (y == 0) || (y == MAZE_H - 1);
    wall   = 1'b1;
    case (lvl)
      3'd0: wall = 1'b1;
      3'd1: wall = border;
      3'd2: wall = border || (((x & 3) == 2) && ((y & 3) != 1));
      3'd3: wall = border || (((y & 3) == 2) && ((x & 3) != 1));
      3'd4: wall = border || (((x ^ y) & 1) == 1);
      3'd5: wall = border || (((x & 1) == 0) && ((y & 1) == 0));
      3'd6: wall = border || ((x & 3) == (y & 3));
      3'd7: wall = border || (((x + y) & 7) == 0);
      default: wall = 1'b1;
    endcase
    return wall;
  endfunction

  // Expand the selected level into one row, column 0 landing in the MSB
  always_comb begin
    row_bits_o = '0;
    for (int x = 0; x < MAZE_W; x++) begin
      row_bits_o[MAZE_W-1-x] = levelWall(level_i, x, int'(row_i));
    end
  end

endmodule

// File: rtl/maze_loader.sv
// Maze loader: streams one cell code per cycle into a maze BRAM in row-major
// order, from a level ROM, a constant fill, or an LFSR-driven random maze.
module maze_loader
  import maze_pkg::*;
#(
  parameter int MAZE_W     = DEFAULT_MAZE_W,
  parameter int MAZE_H     = DEFAULT_MAZE_H,
  parameter int DATA_W     = 9,
  parameter int NUM_LEVELS = 8,
  localparam int N_CELLS   = MAZE_W * MAZE_H,
  localparam int ADDR_W    = $clog2(N_CELLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [2:0]        level,
  input  logic [15:0]       seed,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   wall_count
);

  localparam int XW = $clog2(MAZE_W);
  localparam int YW = $clog2(MAZE_H);

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [2:0]        level_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       lfsr_q;
  logic [ADDR_W:0]   acc_q;
  logic [ADDR_W:0]   wall_count_q;
  logic              err_q;

  logic [MAZE_W-1:0] romRow;
  logic              wantStart;
  logic              reject;
  logic              accept;
  logic              lastCell;
  logic              lastCol;
  logic              border;
  logic [1:0]        cellCode;
  logic              isWall;

  // A LOAD of a level the ROM does not hold is refused without running
  assign wantStart = (state_q == ST_IDLE) && start;
  assign reject    = wantStart && (mode_e'(mode) == MODE_LOAD) && (int'(level) >= NUM_LEVELS);
  assign accept    = wantStart && !reject;
  assign lastCell  = (addr_q == ADDR_W'(N_CELLS - 1));
  assign lastCol   = (x_q == XW'(MAZE_W - 1));
  assign isWall    = (cellCode == CELL_WALL);

  maze_level_rom #(
    .MAZE_W (MAZE_W),
    .MAZE_H (MAZE_H)
  ) u_rom (
    .level_i    (level_q),
    .row_i      (y_q),
    .row_bits_o (romRow)
  );

  // Cell code for the current (x,y): base pattern per mode, then markers
  always_comb begin
    border   = (x_q == '0) || lastCol || (y_q == '0) || (y_q == YW'(MAZE_H - 1));
    cellCode = CELL_PATH;
    case (mode_q)
      MODE_LOAD:   cellCode = romRow[XW'(MAZE_W - 1) - x_q] ? CELL_WALL : CELL_PATH;
      MODE_FILL:   cellCode = CELL_WALL;
      MODE_CLEAR:  cellCode = CELL_PATH;
      MODE_RANDOM: cellCode = (border || (lfsr_q[1:0] == 2'b00)) ? CELL_WALL : CELL_PATH;
      default:     cellCode = CELL_PATH;
    endcase
    if ((mode_q == MODE_LOAD) || (mode_q == MODE_RANDOM)) begin
      if ((x_q == XW'(1)) && (y_q == YW'(1))) begin
        cellCode = CELL_START;
      end else if ((x_q == XW'(MAZE_W - 2)) && (y_q == YW'(MAZE_H - 2))) begin
        cellCode = CELL_EXIT;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: abort beats the final cell, FIN always lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (lastCell) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state so reset silences them at once
  always_comb begin
    we        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    bram_addr = '0;
    bram_data = '0;
    case (state_q)
      ST_RUN: begin
        we        = 1'b1;
        busy      = 1'b1;
        bram_addr = addr_q;
        bram_data = DATA_W'(cellCode);
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  assign err        = err_q;
  assign wall_count = wall_count_q;

  // Job datapath: latch request, walk x/y/addr counters, step LFSR, count walls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= MODE_LOAD;
      level_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      lfsr_q       <= LFSR_DEFAULT_SEED;
      acc_q        <= '0;
      wall_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (reject) begin
          err_q <= 1'b1;
        end
        if (accept) begin
          mode_q  <= mode_e'(mode);
          level_q <= level;
          lfsr_q  <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
          x_q     <= '0;
          y_q     <= '0;
          addr_q  <= '0;
          acc_q   <= '0;
        end
      end else if (state_q == ST_RUN) begin
        if (abort) begin
          err_q <= 1'b1;
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
          lfsr_q <= lfsrNext(lfsr_q);
          acc_q  <= acc_q + (ADDR_W + 1)'(isWall);
          if (lastCol) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
          end else begin
            x_q <= x_q + XW'(1);
          end
          if (lastCell) begin
            wall_count_q <= acc_q + (ADDR_W + 1)'(isWall);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_maze_loader.sv
// Self-checking bench for maze_loader: a 16x16 instance and an 8x6 instance
// with six ROM levels, both checked cell by cell against a behavioural model.
module tb_maze_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        startDrv;
  logic        abortDrv;
  logic [1:0]  modeDrv;
  logic [2:0]  levelDrv;
  logic [15:0] seedDrv;

  logic       startA, abortA, startB, abortB;
  logic [7:0] addrA;
  logic [8:0] dataA;
  logic       weA, busyA, doneA, errA;
  logic [8:0] wcA;
  logic [5:0] addrB;
  logic [8:0] dataB;
  logic       weB, busyB, doneB, errB;
  logic [6:0] wcB;

  logic       obsWe, obsBusy, obsDone, obsErr;
  logic [7:0] obsAddr;
  logic [8:0] obsData;
  logic [8:0] obsWc;

  int compareCount  = 0;
  int mismatchCount = 0;
  int lastWallA     = 0;
  int lastWallB     = 0;
  int expQ[$];

  always #5 clk = ~clk;

  assign startA = startDrv & ~sel;
  assign abortA = abortDrv & ~sel;
  assign startB = startDrv & sel;
  assign abortB = abortDrv & sel;

  maze_loader dutA (
    .clk(clk), .reset(reset), .start(startA), .abort(abortA),
    .mode(modeDrv), .level(levelDrv), .seed(seedDrv),
    .bram_addr(addrA), .bram_data(dataA), .we(weA), .busy(busyA),
    .done(doneA), .err(errA), .wall_count(wcA)
  );

  maze_loader #(.MAZE_W(8), .MAZE_H(6), .NUM_LEVELS(6)) dutB (
    .clk(clk), .reset(reset), .start(startB), .abort(abortB),
    .mode(modeDrv), .level(levelDrv), .seed(seedDrv),
    .bram_addr(addrB), .bram_data(dataB), .we(weB), .busy(busyB),
    .done(doneB), .err(errB), .wall_count(wcB)
  );

  // Route the selected instance onto one set of observation signals
  always_comb begin
    if (sel) begin
      obsWe = weB; obsBusy = busyB; obsDone = doneB; obsErr = errB;
      obsAddr = 8'(addrB); obsData = dataB; obsWc = 9'(wcB);
    end else begin
      obsWe = weA; obsBusy = busyA; obsDone = doneA; obsErr = errA;
      obsAddr = addrA; obsData = dataA; obsWc = wcA;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Level pictures described with plain modular arithmetic
  function automatic int romWall(int lv, int x, int y, int w, int h);
    bit b;
    b = (x == 0) || (x == w - 1) || (y == 0) || (y == h - 1);
    case (lv)
      0: return 1;
      1: return b ? 1 : 0;
      2: return (b || (x % 4 == 2 && y % 4 != 1)) ? 1 : 0;
      3: return (b || (y % 4 == 2 && x % 4 != 1)) ? 1 : 0;
      4: return (b || ((x + y) % 2 == 1)) ? 1 : 0;
      5: return (b || (x % 2 == 0 && y % 2 == 0)) ? 1 : 0;
      6: return (b || (x % 4 == y % 4)) ? 1 : 0;
      default: return (b || ((x + y) % 8 == 0)) ? 1 : 0;
    endcase
  endfunction

  function automatic int modelCell(int m, int lv, int lf, int x, int y, int w, int h);
    int code;
    bit b;
    b = (x == 0) || (x == w - 1) || (y == 0) || (y == h - 1);
    case (m)
      0: code = romWall(lv, x, y, w, h);
      1: code = 1;
      2: code = 0;
      default: code = (b || (lf % 4 == 0)) ? 1 : 0;
    endcase
    if (m == 0 || m == 3) begin
      if (x == 1 && y == 1) code = 2;
      else if (x == w - 2 && y == h - 2) code = 3;
    end
    return code;
  endfunction

  // Build the whole expected write stream for one job
  task automatic buildExpected(input int m, input int lv, input int sd, input int w, input int h);
    int lf, fb;
    expQ.delete();
    lf = (sd == 0) ? 'hACE1 : sd;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        expQ.push_back(modelCell(m, lv, lf, x, y, w, h));
        fb = ((lf >> 15) ^ (lf >> 13) ^ (lf >> 12) ^ (lf >> 10)) & 1;
        lf = ((lf << 1) | fb) & 'hFFFF;
      end
    end
  endtask

  // One job: start (optionally with abort), stream check, then one of
  // abort / stray start / reset injection at a chosen cell, or normal finish
  task automatic applyStimulus(input bit useB, input int m, input int lv, input int sd,
                               input bit abortOnStart, input int abortAt,
                               input int startAt, input int resetAt);
    int w, h, n, walls;
    w = useB ? 8 : 16;
    h = useB ? 6 : 16;
    n = w * h;
    buildExpected(m, lv, sd, w, h);
    walls = 0;
    foreach (expQ[i]) if (expQ[i] == 1) walls++;
    sel = useB; modeDrv = 2'(m); levelDrv = 3'(lv); seedDrv = 16'(sd);
    startDrv = 1'b1; abortDrv = abortOnStart;
    @(posedge clk); #1;
    startDrv = 1'b0; abortDrv = 1'b0;
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("cell%0d", k), {obsWe, obsBusy, obsDone, obsErr, obsAddr, obsData},
                  {1'b1, 1'b1, 1'b0, 1'b0, 8'(k), 9'(expQ[k])});
      if (k == abortAt) begin
        abortDrv = 1'b1;
        @(posedge clk); #1;
        abortDrv = 1'b0;
        checkOutput("abortFlags", {obsWe, obsBusy, obsDone, obsErr}, 4'b0001);
        checkOutput("abortWallCount", obsWc, useB ? lastWallB : lastWallA);
        @(posedge clk); #1;
        checkOutput("abortAfter", {obsWe, obsBusy, obsDone, obsErr}, 4'b0000);
        return;
      end
      if (k == startAt) begin
        startDrv = 1'b1; modeDrv = 2'd1;
      end
      if (k == resetAt) begin
        #2 reset = 1'b1;
        #1 checkOutput("resetMidRun", {obsWe, obsBusy, obsDone, obsErr, obsAddr, obsData, obsWc}, '0);
        @(posedge clk); #1;
        checkOutput("resetHeld", {obsWe, obsBusy, obsDone, obsErr, obsAddr, obsData, obsWc}, '0);
        #3 reset = 1'b0;
        lastWallA = 0; lastWallB = 0;
        for (int c = 0; c < 4; c++) begin
          @(posedge clk); #1;
          checkOutput("afterReset", {obsWe, obsBusy, obsDone, obsErr}, 4'b0000);
        end
        return;
      end
      @(posedge clk); #1;
      startDrv = 1'b0;
    end
    checkOutput("finFlags", {obsWe, obsBusy, obsDone, obsErr}, 4'b0010);
    checkOutput("finWallCount", obsWc, walls);
    if (useB) lastWallB = walls; else lastWallA = walls;
    @(posedge clk); #1;
    checkOutput("idleAfterFin", {obsWe, obsBusy, obsDone, obsErr}, 4'b0000);
  endtask

  // Refused LOAD on the small instance: err pulse only, never busy or writing
  task automatic rejectCheck(input int lv);
    sel = 1'b1; modeDrv = 2'd0; levelDrv = 3'(lv); seedDrv = '0;
    startDrv = 1'b1;
    @(posedge clk); #1;
    startDrv = 1'b0;
    checkOutput("rejectErr", {obsErr, obsBusy, obsWe, obsDone}, 4'b1000);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("rejectIdle", {obsErr, obsBusy, obsWe, obsDone}, 4'b0000);
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; startDrv = 1'b0; abortDrv = 1'b0;
    modeDrv = '0; levelDrv = '0; seedDrv = '0;
    @(posedge clk); #1;
    checkOutput("resetA", {obsWe, obsBusy, obsDone, obsErr, obsAddr, obsData, obsWc}, '0);
    sel = 1'b1; #1;
    checkOutput("resetB", {obsWe, obsBusy, obsDone, obsErr, obsAddr, obsData, obsWc}, '0);
    sel = 1'b0;
    #3 reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] FILL / LOAD / RANDOM on 16x16");
    applyStimulus(0, 1, 0, 0, 0, -1, -1, -1);
    applyStimulus(0, 0, 2, 0, 0, -1, -1, -1);
    applyStimulus(0, 3, 0, 0, 0, -1, -1, -1);
    applyStimulus(0, 3, 0, 'hACE1, 0, -1, -1, -1);
    applyStimulus(0, 3, 0, int'($urandom_range(1, 65535)), 0, -1, -1, -1);
    applyStimulus(0, 0, int'($urandom_range(0, 7)), 0, 0, -1, -1, -1);
    applyStimulus(0, 0, int'($urandom_range(0, 7)), 0, 0, -1, -1, -1);

    $display("[TB] abort, then CLEAR, then start with abort");
    applyStimulus(0, 1, 0, 0, 0, 100, -1, -1);
    applyStimulus(0, 2, 0, 0, 0, -1, -1, -1);
    applyStimulus(0, 0, 1, 0, 1, -1, -1, -1);

    $display("[TB] 8x6 instance");
    rejectCheck(7);
    applyStimulus(1, 2, 0, 0, 0, -1, 10, -1);
    applyStimulus(1, 2, 0, 0, 0, -1, -1, 20);
    applyStimulus(1, 0, 3, 0, 0, -1, -1, -1);
    applyStimulus(1, 3, 0, int'($urandom_range(0, 65535)), 0, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
